evt_xbar_src_port: RTL and testbench

Parametrised destination-side port of the event crossbar. It merges event streams from NUM_SRC upstream masters onto one downstream valid/ready link. Arbitration is round-robin, fixed-priority or static-address. A per-source served mask makes multicast safe: a master broadcasting to several ports is issued exactly once per port, and the master's global ready is built from all ports' served flags. An optional 2-entry output skid buffer registers the downstream interface.

---
 rtl/evt_xbar_src_port.sv | 139 +++++++++++++
 tb/tb_evt_xbar_src_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_xbar_src_port.sv
// Destination-side port of the event crossbar: arbitrates NUM_SRC masters onto one
// valid/ready link, tracks per-master served flags for multicast, optional 2-entry skid.
module evt_xbar_src_port #(
  parameter type T                 = logic,
  parameter int  NUM_SRC           = 4,
  parameter int  ARB_MODE          = 0,
  parameter bit  OUT_REG           = 1'b1,
  parameter int  CNT_W             = 16,
  localparam int IDX_W             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  T                   data_i [NUM_SRC],
  input  logic [NUM_SRC-1:0] valid_i,
  input  logic [NUM_SRC-1:0] dest_en_i,
  output logic [NUM_SRC-1:0] served_o,
  input  logic [NUM_SRC-1:0] clean_i,
  input  logic [IDX_W-1:0]   addr_i,
  output T                   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [IDX_W-1:0]   src_idx_o,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   evt_cnt_o
);

  logic [NUM_SRC-1:0] served_q, req, accept;
  logic [IDX_W-1:0]   gnt_idx, rr_ptr_q, rr_nxt;
  logic               gnt_vld, in_ready, full, push, pop, hs;
  int                 srch_idx;

  T                   fifo_data_q [2];
  logic [IDX_W-1:0]   fifo_idx_q  [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  assign req = valid_i & dest_en_i & ~served_q;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = 0;
    if (NUM_SRC == 1) begin
      gnt_vld = req[0];
    end else if (ARB_MODE == 2) begin
      if (int'(addr_i) < NUM_SRC && req[addr_i]) begin
        gnt_vld = 1'b1;
        gnt_idx = addr_i;
      end
    end else if (ARB_MODE == 1) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end else begin
      // first requester at or above rr_ptr, wrapping around
      for (int i = 0; i < NUM_SRC; i++) begin
        srch_idx = (int'(rr_ptr_q) + i) % NUM_SRC;
        if (!gnt_vld && req[srch_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(srch_idx);
        end
      end
    end
  end

  assign rr_nxt   = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
  assign full     = (count_q == 2'd2);
  assign in_ready = OUT_REG ? ~full : ready_i;

  always_comb begin
    accept = '0;
    if (gnt_vld && in_ready) accept[gnt_idx] = 1'b1;
  end

  // Combinational so a master whose targets all accept together finishes in one cycle.
  assign served_o = served_q | accept | ~dest_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      served_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      served_q <= (served_q | accept) & ~clean_i;
      if (gnt_vld && in_ready) rr_ptr_q <= rr_nxt;
    end
  end

  assign push = OUT_REG && gnt_vld && in_ready;
  assign pop  = (count_q != 2'd0) && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_idx_q[0]  <= '0;
      fifo_idx_q[1]  <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= data_i[gnt_idx];
        fifo_idx_q[wr_ptr_q]  <= gnt_idx;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (!push && pop) count_q <= count_q - 2'd1;
    end
  end

  always_comb begin
    if (OUT_REG) begin
      valid_o   = (count_q != 2'd0);
      data_o    = fifo_data_q[rd_ptr_q];
      src_idx_o = fifo_idx_q[rd_ptr_q];
    end else begin
      valid_o   = gnt_vld;
      data_o    = data_i[gnt_idx];
      src_idx_o = gnt_idx;
    end
  end

  assign hs = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      evt_cnt_o <= '0;
    end else if (hs && (evt_cnt_o != '1)) begin
      evt_cnt_o <= evt_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_evt_xbar_src_port.sv
// Directed bench: round-robin/skid instance (CNT_W=4) checked through an output scoreboard,
// plus a static-address pass-through instance checked directly.
module tb_evt_xbar_src_port;

  typedef logic [7:0] byte_t;
  typedef struct packed { logic [1:0] idx; byte_t d; } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  byte_t       data [4];
  logic [3:0]  valid, dest_en, clean;
  logic [1:0]  addr;
  logic        ready, cnt_clr;

  logic [3:0]  rr_served, st_served;
  byte_t       rr_data, st_data;
  logic        rr_valid, st_valid;
  logic [1:0]  rr_src, st_src;
  logic [3:0]  rr_cnt;
  logic [15:0] st_cnt;

  sb_t         q[$];
  sb_t         it;
  int          n_cmp = 0;
  int          n_mis = 0;
  bit          mon_en = 1'b1;
  int          seq [6] = '{0, 1, 3, 0, 1, 3};

  always #5 clk = ~clk;

  evt_xbar_src_port #(.T(byte_t), .NUM_SRC(4), .ARB_MODE(0), .OUT_REG(1'b1), .CNT_W(4)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .dest_en_i(dest_en),
    .served_o(rr_served), .clean_i(clean), .addr_i(addr), .data_o(rr_data),
    .valid_o(rr_valid), .ready_i(ready), .src_idx_o(rr_src), .cnt_clr_i(cnt_clr),
    .evt_cnt_o(rr_cnt));

  evt_xbar_src_port #(.T(byte_t), .NUM_SRC(4), .ARB_MODE(2), .OUT_REG(1'b0), .CNT_W(16)) u_st (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .dest_en_i(dest_en),
    .served_o(st_served), .clean_i(clean), .addr_i(addr), .data_o(st_data),
    .valid_o(st_valid), .ready_i(ready), .src_idx_o(st_src), .cnt_clr_i(cnt_clr),
    .evt_cnt_o(st_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 4; s++) data[s] = '0;
    valid = '0; dest_en = '0; clean = '0; addr = '0; ready = 1'b0; cnt_clr = 1'b0;
  endtask

  // Checks any downstream handshake of u_rr against the scoreboard, then advances one cycle.
  task automatic step();
    #1;
    if (mon_en && rr_valid && ready) begin
      chk("sb_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        it = q.pop_front();
        chk("out_src", 32'(rr_src), 32'(it.idx));
        chk("out_data", 32'(rr_data), 32'(it.d));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    dest_en = 4'b0101;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rr_valid), 32'd0);
    chk("rst_src", 32'(rr_src), 32'd0);
    chk("rst_data", 32'(rr_data), 32'd0);
    chk("rst_cnt", 32'(rr_cnt), 32'd0);
    chk("rst_served", 32'(rr_served), 32'b1010);
    chk("rst_st_served", 32'(st_served), 32'b1010);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_inputs();

    // single master, one-shot issue while served
    ready = 1'b1; dest_en = 4'b0100; valid = 4'b0100; data[2] = 8'hA2;
    #1 chk("t1_served_acc", 32'(rr_served), 32'b1111);
    q.push_back('{idx: 2'd2, d: 8'hA2});
    step();
    chk("t1_valid", 32'(rr_valid), 32'd1);
    chk("t1_src", 32'(rr_src), 32'd2);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t1_served_hold", 32'(rr_served), 32'b1111);
      step();
    end
    chk("t1_no_reissue", 32'(rr_valid), 32'd0);
    chk("t1_cnt", 32'(rr_cnt), 32'd1);
    valid = '0; clean = 4'b0100;
    step();
    clean = '0;

    // round-robin fairness with clean in each accept cycle
    do_reset();
    ready = 1'b1; dest_en = 4'b1011; valid = 4'b1011;
    for (int s = 0; s < 4; s++) data[s] = 8'hB0 + 8'(s);
    for (int k = 0; k < 6; k++) begin
      clean = 4'(1 << seq[k]);
      #1 chk("t2_served", 32'(rr_served), 32'(4'b0100 | 4'(1 << seq[k])));
      q.push_back('{idx: 2'(seq[k]), d: 8'hB0 + 8'(seq[k])});
      step();
    end
    valid = '0; clean = '0;
    drain();
    chk("t2_cnt", 32'(rr_cnt), 32'd6);

    // backpressure: two accepts fill the skid, master 2 waits
    do_reset();
    ready = 1'b0; dest_en = 4'b0111; valid = 4'b0111;
    for (int s = 0; s < 3; s++) begin
      data[s] = 8'hC0 + 8'(s);
      q.push_back('{idx: 2'(s), d: 8'hC0 + 8'(s)});
    end
    #1 chk("t3_served_c1", 32'(rr_served), 32'b1001);
    step();
    #1 chk("t3_served_c2", 32'(rr_served), 32'b1011);
    step();
    #1 chk("t3_served_full", 32'(rr_served), 32'b1011);
    chk("t3_valid", 32'(rr_valid), 32'd1);
    chk("t3_head_src", 32'(rr_src), 32'd0);
    step();
    ready = 1'b1;
    #1 chk("t3_served_pop1", 32'(rr_served), 32'b1011);
    step();
    #1 chk("t3_served_pop2", 32'(rr_served), 32'b1111);
    step();
    drain();
    valid = '0;

    // clean coincident with accept: next event accepted the very next cycle
    do_reset();
    ready = 1'b1; dest_en = 4'b0001; valid = 4'b0001; data[0] = 8'h50; clean = 4'b0001;
    #1 chk("t5_served_a", 32'(rr_served), 32'b1111);
    q.push_back('{idx: 2'd0, d: 8'h50});
    step();
    clean = '0; data[0] = 8'h51;
    q.push_back('{idx: 2'd0, d: 8'h51});
    step();
    chk("t5_valid", 32'(rr_valid), 32'd1);
    step();
    valid = '0; clean = 4'b0001;
    step();
    clean = '0;
    drain();

    // static address select on the pass-through instance
    do_reset();
    mon_en = 1'b0;
    ready = 1'b1; addr = 2'd3; dest_en = 4'b1010; valid = 4'b1010;
    data[1] = 8'h11; data[3] = 8'h33;
    #1;
    chk("t4_valid_a3", 32'(st_valid), 32'd1);
    chk("t4_src_a3", 32'(st_src), 32'd3);
    chk("t4_data_a3", 32'(st_data), 32'h33);
    chk("t4_served_a3", 32'(st_served), 32'b1101);
    step();
    chk("t4_valid_wait", 32'(st_valid), 32'd0);
    chk("t4_served_wait", 32'(st_served), 32'b1101);
    addr = 2'd1;
    #1;
    chk("t4_valid_a1", 32'(st_valid), 32'd1);
    chk("t4_src_a1", 32'(st_src), 32'd1);
    chk("t4_data_a1", 32'(st_data), 32'h11);
    chk("t4_served_a1", 32'(st_served), 32'b1111);
    step();
    chk("t4_cnt", 32'(st_cnt), 32'd2);
    valid = '0; clean = 4'b1010;
    step();
    clean = '0;
    do_reset();
    mon_en = 1'b1;

    // counter saturation, clear priority, async reset mid-burst
    ready = 1'b1; dest_en = 4'b0001; valid = 4'b0001; clean = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      data[0] = 8'(k);
      q.push_back('{idx: 2'd0, d: 8'(k)});
      step();
    end
    valid = '0; clean = '0;
    drain();
    chk("t6_sat", 32'(rr_cnt), 32'd15);
    valid = 4'b0001; clean = 4'b0001; data[0] = 8'hEE;
    q.push_back('{idx: 2'd0, d: 8'hEE});
    step();
    valid = '0; clean = '0; cnt_clr = 1'b1;
    #1 chk("t6_clr_hs", 32'(rr_valid), 32'd1);
    step();
    cnt_clr = 1'b0;
    chk("t6_clr", 32'(rr_cnt), 32'd0);
    valid = 4'b0001; clean = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      data[0] = 8'h70 + 8'(k);
      q.push_back('{idx: 2'd0, d: 8'h70 + 8'(k)});
      step();
    end
    chk("t6_burst_valid", 32'(rr_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(rr_valid), 32'd0);
    chk("t6_arst_cnt", 32'(rr_cnt), 32'd0);
    chk("t6_arst_served", 32'(rr_served), 32'b1111);
    q.delete();
    clear_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("t6_post_valid", 32'(rr_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
